// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, defaults and entry layout for the register-file
// write-back arbiter.
package regfile_wb_arbiter_pkg;

  localparam int REG_BUS         = 32;
  localparam int REG_NUM_LOG2    = 5;
  localparam int LU_FIFO_DEPTH   = 4;
  localparam int LU_STARVE_LIMIT = 8;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

  typedef struct packed {
    logic                    live;
    logic [REG_NUM_LOG2-1:0] addr;
    logic [REG_BUS-1:0]      data;
  } lu_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Long-latency result FIFO with per-entry live bits that a newer
// pipeline write to the same register can clear in place.
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = REG_BUS,
  parameter int ADDR_W = REG_NUM_LOG2,
  parameter int DEPTH  = LU_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [ADDR_W-1:0]            i_push_addr,
  input  logic [DATA_W-1:0]            i_push_data,
  input  logic                         i_push_live,
  input  logic                         i_pop,
  input  logic                         i_kill,
  input  logic [ADDR_W-1:0]            i_kill_addr,
  output logic                         o_full,
  output logic                         o_head_valid,
  output logic                         o_head_live,
  output logic [ADDR_W-1:0]            o_head_addr,
  output logic [DATA_W-1:0]            o_head_data,
  output logic [DEPTH-1:0]             o_ent_valid,
  output logic [DEPTH-1:0]             o_ent_live,
  output logic [DEPTH-1:0][ADDR_W-1:0] o_ent_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]            r_rd;
  logic [PTR_W-1:0]            r_wr;
  logic [CNT_W-1:0]            r_cnt;
  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0]            r_live;
  logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;
  logic                        w_push_kill;

  assign w_push_kill = i_kill && (i_push_addr == i_kill_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_cnt   <= '0;
      r_valid <= '0;
      r_live  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_kill && r_valid[i] && r_addr[i] == i_kill_addr)
          r_live[i] <= 1'b0;
      end
      if (i_pop) begin
        r_valid[r_rd] <= 1'b0;
        r_rd          <= r_rd + PTR_W'(1);
      end
      // The push slot is never valid, so its live bit overrides the kill loop
      if (i_push) begin
        r_valid[r_wr] <= 1'b1;
        r_live[r_wr]  <= i_push_live && !w_push_kill;
        r_addr[r_wr]  <= i_push_addr;
        r_data[r_wr]  <= i_push_data;
        r_wr          <= r_wr + PTR_W'(1);
      end
      r_cnt <= r_cnt + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  assign o_full       = (r_cnt == CNT_W'(DEPTH));
  assign o_head_valid = r_valid[r_rd];
  assign o_head_live  = r_live[r_rd];
  assign o_head_addr  = r_addr[r_rd];
  assign o_head_data  = r_data[r_rd];
  assign o_ent_valid  = r_valid;
  assign o_ent_live   = r_live;
  assign o_ent_addr   = r_addr;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline write-back first, buffered
// long-latency results drained into idle cycles, plus pending-write scoreboard.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W       = REG_BUS,
  parameter int ADDR_W       = REG_NUM_LOG2,
  parameter int DEPTH        = LU_FIFO_DEPTH,
  parameter int STARVE_LIMIT = LU_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [ADDR_W-1:0] lu_waddr,
  input  logic [DATA_W-1:0] lu_wdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              pend_hit1,
  output logic              pend_hit2,
  output logic              stall_req
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  logic                         w_full;
  logic                         w_head_valid;
  logic                         w_head_live;
  logic [ADDR_W-1:0]            w_head_addr;
  logic [DATA_W-1:0]            w_head_data;
  logic [DEPTH-1:0]             w_ent_valid;
  logic [DEPTH-1:0]             w_ent_live;
  logic [DEPTH-1:0][ADDR_W-1:0] w_ent_addr;

  logic w_wb_act;
  logic w_push;
  logic w_pop;
  logic w_hit1;
  logic w_hit2;
  logic [SC_W-1:0] r_starve;

  assign w_wb_act = wb_we && (wb_waddr != '0);
  assign lu_ready = !rst && !w_full;
  assign w_push   = lu_valid && lu_ready;
  // A dead head leaves without the port; a live one needs the port free
  assign w_pop    = w_head_valid && (!w_head_live || !w_wb_act);

  wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_addr  (lu_waddr),
    .i_push_data  (lu_wdata),
    .i_push_live  (lu_waddr != '0),
    .i_pop        (w_pop),
    .i_kill       (w_wb_act),
    .i_kill_addr  (wb_waddr),
    .o_full       (w_full),
    .o_head_valid (w_head_valid),
    .o_head_live  (w_head_live),
    .o_head_addr  (w_head_addr),
    .o_head_data  (w_head_data),
    .o_ent_valid  (w_ent_valid),
    .o_ent_live   (w_ent_live),
    .o_ent_addr   (w_ent_addr)
  );

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (!rst) begin
      if (w_wb_act) begin
        rf_we    = 1'b1;
        rf_waddr = wb_waddr;
        rf_wdata = wb_wdata;
      end else if (w_head_valid && w_head_live) begin
        rf_we    = 1'b1;
        rf_waddr = w_head_addr;
        rf_wdata = w_head_data;
      end
    end
  end

  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_valid[i] && w_ent_live[i]) begin
        if (w_ent_addr[i] == raddr1) w_hit1 = 1'b1;
        if (w_ent_addr[i] == raddr2) w_hit2 = 1'b1;
      end
    end
  end

  assign pend_hit1 = !rst && (raddr1 != '0) && w_hit1;
  assign pend_hit2 = !rst && (raddr2 != '0) && w_hit2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (!w_head_valid || w_pop) begin
      r_starve <= '0;
    end else if (r_starve != SC_W'(STARVE_LIMIT)) begin
      r_starve <= r_starve + SC_W'(1);
    end
  end

  assign stall_req = !rst && (r_starve == SC_W'(STARVE_LIMIT));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus
// hand-written reset, full, and starvation sequences.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        pend_hit1;
  logic        pend_hit2;
  logic        stall_req;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] shadow [32];

  regfile_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .wb_we     (wb_we),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .lu_valid  (lu_valid),
    .lu_ready  (lu_ready),
    .lu_waddr  (lu_waddr),
    .lu_wdata  (lu_wdata),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .pend_hit1 (pend_hit1),
    .pend_hit2 (pend_hit2),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rf_we) shadow[rf_waddr] <= rf_wdata;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_rdy;
    logic        e_h1;
    logic        e_h2;
    logic        e_st;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(
    input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic lv, input logic [4:0] la, input logic [31:0] ld,
    input logic [4:0] r1, input logic [4:0] r2,
    input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd,
    input logic e_rdy, input logic e_h1, input logic e_h2,
    input logic e_st);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd;
    v.lv = lv; v.la = la; v.ld = ld;
    v.r1 = r1; v.r2 = r2;
    v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd;
    v.e_rdy = e_rdy; v.e_h1 = e_h1; v.e_h2 = e_h2;
    v.e_st = e_st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic lv, input logic [4:0] la, input logic [31:0] ld,
    input logic [4:0] r1, input logic [4:0] r2);
    wb_we = we; wb_waddr = wa; wb_wdata = wd;
    lu_valid = lv; lu_waddr = la; lu_wdata = ld;
    raddr1 = r1; raddr2 = r2;
  endtask

  task automatic chk_out(
    input string tag, input logic e_we, input logic [4:0] e_wa,
    input logic [31:0] e_wd, input logic e_rdy, input logic e_h1,
    input logic e_h2, input logic e_st);
    chk({tag, ".rf_we"}, rf_we, e_we);
    if (e_we) begin
      chk({tag, ".rf_waddr"}, rf_waddr, e_wa);
      chk({tag, ".rf_wdata"}, rf_wdata, e_wd);
    end
    chk({tag, ".lu_ready"}, lu_ready, e_rdy);
    chk({tag, ".pend_hit1"}, pend_hit1, e_h1);
    chk({tag, ".pend_hit2"}, pend_hit2, e_h2);
    chk({tag, ".stall_req"}, stall_req, e_st);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = '0;

    // idle drain of addr 5
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 5, 0,
                 0, 0, 0, 1, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0,
                 0, 0, 0, 1, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 5, 5,
                 1, 5, 32'hDEADBEEF, 1, 1, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 5, 0,
                 0, 0, 0, 1, 0, 0, 0);
    // WAW kill on addr 9
    tbl[4]  = mk(0, 0, 0, 1, 9, 32'h1111, 9, 0,
                 0, 0, 0, 1, 0, 0, 0);
    tbl[5]  = mk(1, 9, 32'h2222, 0, 0, 0, 9, 9,
                 1, 9, 32'h2222, 1, 1, 1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 9, 9,
                 0, 0, 0, 1, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 9, 0,
                 0, 0, 0, 1, 0, 0, 0);
    // addr-0 long-latency result is dead on arrival
    tbl[8]  = mk(1, 3, 32'h33, 1, 0, 32'hFFFFFFFF, 0, 0,
                 1, 3, 32'h33, 1, 0, 0, 0);
    tbl[9]  = mk(1, 3, 32'h34, 0, 0, 0, 0, 0,
                 1, 3, 32'h34, 1, 0, 0, 0);
    // write-back to x0 does not use the port
    tbl[10] = mk(1, 0, 32'h55, 0, 0, 0, 0, 0,
                 0, 0, 0, 1, 0, 0, 0);
    // same-cycle accept and WAW kill
    tbl[11] = mk(1, 12, 32'hC, 1, 12, 32'hBAD, 12, 0,
                 1, 12, 32'hC, 1, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 12, 0,
                 0, 0, 0, 1, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 1, 0, 0, 0);

    rst = 1'b1;
    drive(1, 3, 32'h77, 1, 6, 32'h66, 6, 3);
    tick();
    #1;
    chk_out("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset.rf_waddr", rf_waddr, 0);
    chk("reset.rf_wdata", rf_wdata, 0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].lv,
            tbl[i].la, tbl[i].ld, tbl[i].r1, tbl[i].r2);
      #1;
      chk_out($sformatf("vec%0d", i), tbl[i].e_we, tbl[i].e_wa,
              tbl[i].e_wd, tbl[i].e_rdy, tbl[i].e_h1,
              tbl[i].e_h2, tbl[i].e_st);
      tick();
    end
    chk("waw.reg9", shadow[9], 32'h2222);
    chk("waw.reg12", shadow[12], 32'hC);
    chk("dead0.reg0", shadow[0], 32'h0);

    // priority and full: write-back holds the port every cycle
    for (int i = 0; i < 4; i++) begin
      drive(1, 3, 32'h300 + i, 1, 5'(7 + i), 32'hA0 + i, 7, 0);
      #1;
      chk_out($sformatf("fill%0d", i), 1, 3, 32'h300 + i,
              1, (i > 0), 0, 0);
      tick();
    end
    for (int j = 0; j < 2; j++) begin
      drive(1, 3, 32'h310 + j, 1, 11, 32'hBB, 10, 11);
      #1;
      chk_out($sformatf("held%0d", j), 1, 3, 32'h310 + j,
              0, 1, 0, 0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 5'(7 + i), 11);
      #1;
      chk_out($sformatf("drain%0d", i), 1, 5'(7 + i), 32'hA0 + i,
              (i > 0), 1, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 10, 11);
    #1;
    chk_out("drained", 0, 0, 0, 1, 0, 0, 0);
    tick();

    // starvation: head for addr 6 blocked by write-back to addr 4
    drive(1, 4, 32'h40, 1, 6, 32'h66, 6, 0);
    #1;
    chk_out("starve.acc", 1, 4, 32'h40, 1, 0, 0, 0);
    tick();
    for (int k = 0; k < 8; k++) begin
      drive(1, 4, 32'h41 + k, 0, 0, 0, 6, 0);
      #1;
      chk_out($sformatf("starve%0d", k), 1, 4, 32'h41 + k,
              1, 1, 0, 0);
      tick();
    end
    drive(1, 4, 32'h50, 0, 0, 0, 6, 0);
    #1;
    chk_out("starve.hit", 1, 4, 32'h50, 1, 1, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 6, 0);
    #1;
    chk_out("starve.drain", 1, 6, 32'h66, 1, 1, 0, 1);
    tick();
    #1;
    chk_out("starve.clear", 0, 0, 0, 1, 0, 0, 0);
    chk("starve.reg6", shadow[6], 32'h66);

    // reset mid-operation with three buffered results
    for (int i = 0; i < 3; i++) begin
      drive(1, 3, 32'h900 + i, 1, 5'(20 + i), 32'hE0 + i, 20, 22);
      #1;
      chk_out($sformatf("rfill%0d", i), 1, 3, 32'h900 + i,
              1, (i > 0), 0, 0);
      tick();
    end
    drive(1, 3, 32'h999, 0, 0, 0, 20, 22);
    #1;
    chk_out("rpre", 1, 3, 32'h999, 1, 1, 1, 0);
    rst = 1'b1;
    #1;
    chk_out("rmid", 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 20, 22);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_out($sformatf("rpost%0d", i), 0, 0, 0, 1, 0, 0, 0);
      tick();
    end
    chk("rpost.reg20", shadow[20], 32'h0);
    chk("rpost.reg22", shadow[22], 32'h0);

    // four fresh accepts must fit again, proving the count was cleared
    for (int i = 0; i < 4; i++) begin
      drive(1, 3, 32'hA00, 1, 5'(24 + i), 32'hF0 + i, 0, 0);
      #1;
      chk($sformatf("refill%0d.lu_ready", i), lu_ready, 1);
      tick();
    end
    drive(1, 3, 32'hA00, 1, 28, 32'hFF, 0, 0);
    #1;
    chk("refill.full", lu_ready, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two requesters: the in-order pipeline write-back stage and the long-latency unit return path (divider, load-miss return).
- Pipeline write-back always has priority and is never back-pressured.
- Long-latency results are buffered in a small FIFO and drained into idle write-port cycles.
- Also provides a pending-write scoreboard. ID uses it to stall reads of registers that still have buffered results in flight.

Parameters:
- DATA_W, 32, register data width (`RegBus).
- ADDR_W, 5, register address width (`RegNumLog2).
- DEPTH, 4, long-latency FIFO entries; power of two, at least 2.
- STARVE_LIMIT, 8, cycles a valid FIFO head may wait before stall_req asserts.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset (`RstEnable = 1).
- wb_we  in  1  pipeline write-back write enable.
- wb_waddr  in  ADDR_W  pipeline write-back destination register.
- wb_wdata  in  DATA_W  pipeline write-back data.
- lu_valid  in  1  long-latency result valid.
- lu_ready  out  1  FIFO can accept; equals !full; 0 while rst = 1.
- lu_waddr  in  ADDR_W  long-latency destination register.
- lu_wdata  in  DATA_W  long-latency result data.
- rf_we  out  1  to register-file write enable.
- rf_waddr  out  ADDR_W  to register-file write address.
- rf_wdata  out  DATA_W  to register-file write data.
- raddr1  in  ADDR_W  ID-stage read address, port 1.
- raddr2  in  ADDR_W  ID-stage read address, port 2.
- pend_hit1  out  1  raddr1 has a live buffered write.
- pend_hit2  out  1  raddr2 has a live buffered write.
- stall_req  out  1  request to freeze the pipeline so the FIFO head can drain.

Behaviour:
- Reset (synchronous, rst = 1 at a clock edge):
  - FIFO pointers, count, entry valid and live bits, and the starve counter are cleared.
  - All buffered results are discarded, including during reset mid-operation.
  - While rst = 1, all outputs are 0: rf_we = 0, rf_waddr = 0, rf_wdata = 0, lu_ready = 0, pend_hit1/2 = 0, stall_req = 0.
- Accept: when lu_valid && lu_ready at a clock edge, the tail entry is written with {addr, data, live = (lu_waddr != 0)}.
  - An entry with lu_waddr = 0 is enqueued dead.
- Port free: the write port is free when !(wb_we && wb_waddr != 0).
- Write-port mux (combinational, zero latency for write-back):
  - If wb_we && wb_waddr != 0: rf_* = wb_*.
  - Else if the FIFO head is valid and live: rf_we = 1, rf_* = head; the head pops at the edge.
  - Else: rf_we = 0.
- Dead head: pops in one cycle without using the port, regardless of wb_we.
- Minimum latency from lu accept to rf_we is 1 cycle. There is no bypass around the FIFO.
- Full: lu_ready = 0, so there is no accept; a pop in the same cycle does not raise lu_ready until the next cycle.
- Simultaneous push and pop when not full: count is unchanged and the pointers wrap modulo DEPTH.
- WAW kill: in any cycle where wb_we && wb_waddr != 0, every valid FIFO entry with a matching addr has its live bit cleared at the edge.
  - This includes an entry being accepted in the same cycle with a matching addr; it is enqueued dead.
  - The older buffered value therefore never overwrites the newer pipeline value.
- Scoreboard: pend_hitN = (raddrN != 0) && OR over valid, live entries of (entry.addr == raddrN). It is combinational and reflects the current-cycle FIFO state only.
- Starvation:
  - starve_cnt increments each cycle the head is valid, live and not popped.
  - starve_cnt clears on a pop or when the FIFO is empty, and saturates at STARVE_LIMIT.
  - stall_req = (starve_cnt == STARVE_LIMIT); it holds until the head pops.
  - While stalled, the pipeline holds wb_we = 0 from the next cycle; the head then drains and stall_req drops the cycle after the pop.

Decomposition:
- Shared package/defines: existing `RegBus, `RegAddrBus, `RegNumLog2, `RstEnable, `WriteEnable, `ZeroWord.
- New shared defines: `LuFifoDepth and `StarveLimit defaults.
- Entry struct {live, addr, data} lives in the package.
- Sub-module: wb_fifo, a parameterized synchronous FIFO with a per-entry live-kill input and per-entry addr/valid/live exposed for the scoreboard compare. Arbitration mux, scoreboard and starve counter stay in the top.

Test Plan:
- Reset mid-operation: 3 entries queued, then rst = 1 for 1 cycle. Required: count = 0, pend_hit1 = 0 for those addresses, lu_ready = 1 the cycle after rst drops, no rf_we of the discarded data.
- Idle drain: wb_we = 0; accept lu addr 5, data 0xDEADBEEF at cycle t. Required: rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF at cycle t+1; pend_hit1 (raddr1 = 5) = 1 at t+1 only.
- Priority/full: wb_we = 1 to addr 3 every cycle; push 4 lu results to addrs 7/8/9/10. Required: rf_* follows wb only; lu_ready = 0 after the 4th accept; a 5th lu_valid is held off; entries drain in order 7, 8, 9, 10 once wb_we drops.
- WAW kill: lu writes addr 9, data 0x1111 is buffered; wb writes addr 9, data 0x2222. Required: the entry goes dead, pend_hit for addr 9 = 0, and the entry pops without rf_we. Register 9 final value is 0x2222.
- Starvation: head buffered with wb_we = 1 (addr 4) for 8 cycles. Required: stall_req = 1 on cycle 8; bench drops wb_we; head writes next cycle; stall_req = 0 the cycle after.
- Addr-0 lu result: accept lu_waddr = 0, data 0xFFFFFFFF while wb_we = 1 to addr 3. Required: entry is dead, pops the next cycle with no rf_we, pend_hitN for raddrN = 0 is 0, and the count returns to 0.
